fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/riscv_pkg.sv | 6 +
 rtl/fetch_unit.sv | 103 ++++++++++
 tb/tb_fetch_unit.sv | 134 +++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch-state encoding and instruction/PC constants
package riscv_pkg;
    typedef enum logic [1:0] {BOOT, RUN, HOLD, TRAP} fetch_state_t;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_INCR   = 32'd4;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: single-issue instruction fetch with stall hold and redirect; FETCH_MISALIGN_TRAP_EN enables the misaligned-redirect trap
import riscv_pkg::*;
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:2] i_addr,
    input  logic [31:0] i_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        f_valid,
    output logic [31:0] f_pc,
    output logic [31:0] f_instr,
    output logic        fetch_exc
);
    fetch_state_t r_state, w_state_nxt;
    logic [31:0] r_fpc, w_fpc_nxt, r_hold, w_hold_nxt, w_pc_inc, w_redir_pc;
    logic r_exc, w_exc_nxt, w_misalign;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign w_misalign = |redirect_pc[1:0];
`else
    assign w_misalign = 1'b0;
`endif
    assign w_pc_inc   = r_fpc + PC_INCR;
    assign w_redir_pc = w_misalign ? redirect_pc : (redirect_pc & ~32'h3);
    // state register, presented PC, hold buffer and sticky trap flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BOOT;
            r_fpc   <= RESET_PC;
            r_hold  <= NOP_INSTR;
            r_exc   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_fpc   <= w_fpc_nxt;
            r_hold  <= w_hold_nxt;
            r_exc   <= w_exc_nxt;
        end
    end
    // next state: redirect wins over stall; the PC only advances when the consumer takes an instruction
    always_comb begin
        w_state_nxt = r_state;
        w_fpc_nxt   = r_fpc;
        w_hold_nxt  = r_hold;
        w_exc_nxt   = r_exc;
        if (redirect_valid) begin
            w_state_nxt = w_misalign ? TRAP : RUN;
            w_fpc_nxt   = w_redir_pc;
            w_hold_nxt  = NOP_INSTR;
            w_exc_nxt   = w_misalign;
        end else begin
            case (r_state)
                BOOT: begin
                    w_state_nxt = RUN;
                    w_fpc_nxt   = RESET_PC;
                end
                RUN: begin
                    w_state_nxt = stall ? HOLD : RUN;
                    w_fpc_nxt   = stall ? r_fpc : w_pc_inc;
                    w_hold_nxt  = stall ? i_rdata : r_hold;
                end
                HOLD: begin
                    w_state_nxt = stall ? HOLD : RUN;
                    w_fpc_nxt   = stall ? r_fpc : w_pc_inc;
                end
                TRAP: w_state_nxt = TRAP;
                default: w_state_nxt = BOOT;
            endcase
        end
    end
    // outputs: reset values while rst is high, a bubble on redirect, otherwise the fetched or held word
    always_comb begin
        i_addr    = RESET_PC[31:2];
        f_valid   = 1'b0;
        f_pc      = RESET_PC;
        f_instr   = NOP_INSTR;
        fetch_exc = 1'b0;
        if (!rst) begin
            f_pc      = r_fpc;
            fetch_exc = r_exc;
            if (redirect_valid) begin
                i_addr = redirect_pc[31:2];
            end else begin
                case (r_state)
                    RUN: begin
                        f_valid = 1'b1;
                        f_instr = i_rdata;
                        i_addr  = w_pc_inc[31:2];
                    end
                    HOLD: begin
                        f_valid = 1'b1;
                        f_instr = r_hold;
                        i_addr  = w_pc_inc[31:2];
                    end
                    TRAP: i_addr = r_fpc[31:2];
                    default: i_addr = RESET_PC[31:2];
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench for fetch_unit (RESET_PC=0x100), both FETCH_MISALIGN_TRAP_EN builds
import riscv_pkg::*;
module tb_fetch_unit;
    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] ia;
        logic        exc;
        logic        cpc;
        logic        cia;
        logic        cexc;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:2] i_addr;
    logic [31:0] i_rdata = 32'h0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        f_valid;
    logic [31:0] f_pc;
    logic [31:0] f_instr;
    logic        fetch_exc;
    int checks = 0;
    int failures = 0;
    exp_t q[$];
    fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .rst(rst), .i_addr(i_addr), .i_rdata(i_rdata), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .f_valid(f_valid), .f_pc(f_pc), .f_instr(f_instr), .fetch_exc(fetch_exc)
    );
    always #5 clk = ~clk;
    function automatic logic [31:0] m(input logic [31:0] a);
        return {a[31:2], 2'b11} ^ 32'hC0DE_0000;
    endfunction
    always @(posedge clk) i_rdata <= m({i_addr, 2'b00});
    function automatic exp_t e(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                               input logic [31:0] ia, input logic exc,
                               input logic cpc = 1'b1, input logic cia = 1'b1, input logic cexc = 1'b1);
        exp_t x;
        x.v = v; x.pc = pc; x.ins = ins; x.ia = ia; x.exc = exc;
        x.cpc = cpc; x.cia = cia; x.cexc = cexc;
        return x;
    endfunction
    task automatic cyc(input string tag, input logic r, input logic s, input logic rv,
                       input logic [31:0] rpc, input exp_t x);
        exp_t y;
        rst = r; stall = s; redirect_valid = rv; redirect_pc = rpc;
        q.push_back(x);
        @(negedge clk);
        y = q.pop_front();
        checks++;
        assert (f_valid === y.v) else begin
            failures++;
            $error("FAIL %s f_valid got=%0b exp=%0b", tag, f_valid, y.v);
        end
        checks++;
        assert (f_instr === y.ins) else begin
            failures++;
            $error("FAIL %s f_instr got=%h exp=%h", tag, f_instr, y.ins);
        end
        if (y.cpc) begin
            checks++;
            assert (f_pc === y.pc) else begin
                failures++;
                $error("FAIL %s f_pc got=%h exp=%h", tag, f_pc, y.pc);
            end
        end
        if (y.cia) begin
            checks++;
            assert (i_addr === y.ia[31:2]) else begin
                failures++;
                $error("FAIL %s i_addr got=%h exp=%h", tag, {i_addr, 2'b00}, y.ia);
            end
        end
        if (y.cexc) begin
            checks++;
            assert (fetch_exc === y.exc) else begin
                failures++;
                $error("FAIL %s fetch_exc got=%0b exp=%0b", tag, fetch_exc, y.exc);
            end
        end
        @(posedge clk);
        #1;
    endtask
    initial begin
        #100000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
    initial begin
        @(posedge clk);
        #1;
        cyc("reset0", 1, 0, 0, 0, e(0, 32'h100, NOP_INSTR, 32'h100, 0));
        cyc("reset1", 1, 0, 1, 32'h500, e(0, 32'h100, NOP_INSTR, 32'h100, 0));
        cyc("boot", 0, 0, 0, 0, e(0, 32'h100, NOP_INSTR, 32'h100, 0));
        cyc("run100", 0, 0, 0, 0, e(1, 32'h100, m(32'h100), 32'h104, 0));
        cyc("stall1", 0, 1, 0, 0, e(1, 32'h104, m(32'h104), 32'h108, 0));
        cyc("stall2", 0, 1, 0, 0, e(1, 32'h104, m(32'h104), 32'h108, 0));
        cyc("stall3", 0, 1, 0, 0, e(1, 32'h104, m(32'h104), 32'h108, 0));
        cyc("take104", 0, 0, 0, 0, e(1, 32'h104, m(32'h104), 32'h108, 0));
        cyc("run108", 0, 0, 0, 0, e(1, 32'h108, m(32'h108), 32'h10C, 0));
        cyc("stall10c", 0, 1, 0, 0, e(1, 32'h10C, m(32'h10C), 32'h110, 0));
        cyc("redir_hold", 0, 1, 1, 32'h200, e(0, 0, NOP_INSTR, 32'h200, 0, 0));
        cyc("run200", 0, 0, 0, 0, e(1, 32'h200, m(32'h200), 32'h204, 0));
        cyc("run204", 0, 0, 0, 0, e(1, 32'h204, m(32'h204), 32'h208, 0));
        cyc("redir_top", 0, 0, 1, 32'hFFFF_FFF8, e(0, 0, NOP_INSTR, 32'hFFFF_FFF8, 0, 0));
        cyc("runfff8", 0, 0, 0, 0, e(1, 32'hFFFF_FFF8, m(32'hFFFF_FFF8), 32'hFFFF_FFFC, 0));
        cyc("runfffc", 0, 0, 0, 0, e(1, 32'hFFFF_FFFC, m(32'hFFFF_FFFC), 32'h0, 0));
        cyc("wrap0", 0, 0, 0, 0, e(1, 32'h0, m(32'h0), 32'h4, 0));
`ifdef FETCH_MISALIGN_TRAP_EN
        cyc("redir202", 0, 0, 1, 32'h202, e(0, 0, NOP_INSTR, 32'h200, 0, 0));
        cyc("trap1", 0, 0, 0, 0, e(0, 32'h202, NOP_INSTR, 0, 1, 1, 0));
        cyc("trap2", 0, 1, 0, 0, e(0, 32'h202, NOP_INSTR, 0, 1, 1, 0));
        cyc("redir300", 0, 0, 1, 32'h300, e(0, 0, NOP_INSTR, 32'h300, 0, 0, 1, 0));
        cyc("run300", 0, 0, 0, 0, e(1, 32'h300, m(32'h300), 32'h304, 0));
`else
        cyc("redir202", 0, 0, 1, 32'h202, e(0, 0, NOP_INSTR, 32'h200, 0, 0));
        cyc("run200a", 0, 0, 0, 0, e(1, 32'h200, m(32'h200), 32'h204, 0));
        cyc("run204a", 0, 0, 0, 0, e(1, 32'h204, m(32'h204), 32'h208, 0));
`endif
        cyc("redir400", 0, 0, 1, 32'h400, e(0, 0, NOP_INSTR, 32'h400, 0, 0));
        cyc("stall400", 0, 1, 0, 0, e(1, 32'h400, m(32'h400), 32'h404, 0));
        cyc("hold400", 0, 1, 0, 0, e(1, 32'h400, m(32'h400), 32'h404, 0));
        cyc("rst_stall", 1, 1, 0, 0, e(0, 32'h100, NOP_INSTR, 32'h100, 0));
        cyc("boot2", 0, 1, 0, 0, e(0, 32'h100, NOP_INSTR, 32'h100, 0));
        cyc("run100s", 0, 1, 0, 0, e(1, 32'h100, m(32'h100), 32'h104, 0));
        cyc("take100", 0, 0, 0, 0, e(1, 32'h100, m(32'h100), 32'h104, 0));
        cyc("run104b", 0, 0, 0, 0, e(1, 32'h104, m(32'h104), 32'h108, 0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
